// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: cell encodings, field defaults,
// apple-spawner FSM encoding and the LFSR polynomial.
package snake_pkg;

   typedef logic [1:0] cell_t;

   localparam cell_t EMPTY = 2'b00;
   localparam cell_t SNAKE = 2'b01;
   localparam cell_t APPLE = 2'b10;
   localparam cell_t BLOCK = 2'b11;

   localparam int unsigned DEF_SIZE_X = 10;
   localparam int unsigned DEF_SIZE_Y = 10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REDUCE = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Taps 16,14,13,11 map to state bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input logic [15:0] taps);
      return {cur[14:0], ^(cur & taps)};
   endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; shifts left, feedback enters at bit 0.
module snake_lfsr
   import snake_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   logic [15:0] state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
      end else begin
         state_q <= lfsr_next(state_q, LFSR_TAPS);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/apple_spawner.sv
// Places an apple on the k-th empty cell of a captured field, where k is an LFSR sample
// reduced modulo the empty-cell count by repeated subtraction.
module apple_spawner
   import snake_pkg::*;
#(
   parameter int unsigned SIZE_X = DEF_SIZE_X,
   parameter int unsigned SIZE_Y = DEF_SIZE_Y,
   parameter logic [15:0] SEED   = LFSR_SEED
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [2*SIZE_X*SIZE_Y-1:0] field,
   input  logic [15:0]                empty_cells,
   output logic [7:0]                 apple_x,
   output logic [7:0]                 apple_y,
   output logic                       apple_valid,
   output logic                       no_room,
   output logic                       busy
);

   localparam int unsigned N_CELLS  = SIZE_X * SIZE_Y;
   localparam int unsigned FIELD_W  = 2 * N_CELLS;
   localparam logic [7:0]  IDX_LAST = 8'(N_CELLS - 1);
   localparam logic [7:0]  X_LAST   = 8'(SIZE_X - 1);

   logic [15:0] lfsr;
   logic        unused_lfsr_hi;

   snake_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   assign unused_lfsr_hi = ^lfsr[15:7];

   logic [1:0]         state_q, state_d;
   logic [FIELD_W-1:0] field_q, field_d;
   logic [15:0]        empty_q, empty_d;
   logic [7:0]         k_q, k_d;
   logic [7:0]         idx_q, idx_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [7:0]         x_q, x_d;
   logic [7:0]         y_q, y_d;
   logic               found_q, found_d;
   logic [7:0]         apple_x_q, apple_x_d;
   logic [7:0]         apple_y_q, apple_y_d;
   logic               valid_q, valid_d;
   logic               no_room_q, no_room_d;
   logic               cell_empty;

   // The captured field is shifted down two bits per scanned cell, so the cell under
   // examination is always in the low bits and no index mux is needed.
   assign cell_empty = (field_q[1:0] == EMPTY);

   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      empty_d   = empty_q;
      k_d       = k_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      found_d   = found_q;
      apple_x_d = apple_x_q;
      apple_y_d = apple_y_q;
      valid_d   = 1'b0;
      no_room_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               field_d = field;
               empty_d = empty_cells;
               k_d     = {1'b0, lfsr[6:0]};
               found_d = 1'b0;
               state_d = (empty_cells == 16'd0) ? ST_DONE : ST_REDUCE;
            end
         end

         ST_REDUCE: begin
            if ({8'd0, k_q} >= empty_q) begin
               k_d = k_q - empty_q[7:0];
            end else begin
               state_d = ST_SCAN;
               idx_d   = 8'd0;
               cnt_d   = 8'd0;
               x_d     = 8'd0;
               y_d     = 8'd0;
            end
         end

         ST_SCAN: begin
            if (cell_empty && (cnt_q == k_q)) begin
               apple_x_d = x_q;
               apple_y_d = y_q;
               found_d   = 1'b1;
               state_d   = ST_DONE;
            end else begin
               if (cell_empty) begin
                  cnt_d = cnt_q + 8'd1;
               end
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
               end
               field_d = field_q >> 2;
               idx_d   = idx_q + 8'd1;
               if (x_q == X_LAST) begin
                  x_d = 8'd0;
                  y_d = y_q + 8'd1;
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end

         ST_DONE: begin
            valid_d   = found_q;
            no_room_d = ~found_q;
            state_d   = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         field_q   <= '0;
         empty_q   <= 16'd0;
         k_q       <= 8'd0;
         idx_q     <= 8'd0;
         cnt_q     <= 8'd0;
         x_q       <= 8'd0;
         y_q       <= 8'd0;
         found_q   <= 1'b0;
         apple_x_q <= 8'd0;
         apple_y_q <= 8'd0;
         valid_q   <= 1'b0;
         no_room_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         empty_q   <= empty_d;
         k_q       <= k_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         found_q   <= found_d;
         apple_x_q <= apple_x_d;
         apple_y_q <= apple_y_d;
         valid_q   <= valid_d;
         no_room_q <= no_room_d;
      end
   end

   assign apple_x     = apple_x_q;
   assign apple_y     = apple_y_q;
   assign apple_valid = valid_q;
   assign no_room     = no_room_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner on the default 10x10 field, using a reference
// LFSR and placement model feeding a scoreboard queue.
module tb_apple_spawner;

   localparam int N = 100;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct {
      logic       found;
      logic [7:0] x;
      logic [7:0] y;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [2*N-1:0] field = '0;
   logic [15:0]    empty_cells = 16'd0;
   logic [7:0]     apple_x, apple_y;
   logic           apple_valid, no_room, busy;

   logic [15:0]    ref_lfsr;
   int             total = 0;
   int             bad = 0;
   exp_t           exp_q[$];
   logic [7:0]     last_x = 8'd0;
   logic [7:0]     last_y = 8'd0;
   logic [2*N-1:0] all_empty;
   logic [2*N-1:0] all_block;

   always #5 clk = ~clk;

   apple_spawner dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .field       (field),
      .empty_cells (empty_cells),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .apple_valid (apple_valid),
      .no_room     (no_room),
      .busy        (busy)
   );

   // Reference LFSR: taps 16,14,13,11 -> bits 15,13,12,10.
   always @(posedge clk) begin
      if (rst) ref_lfsr <= SEED;
      else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle; r is the random value the DUT samples with it.
   task automatic fire(input logic [2*N-1:0] f, input logic [15:0] e, output int r);
      field       = f;
      empty_cells = e;
      start       = 1'b1;
      r           = int'(ref_lfsr[6:0]);
      tick();
      start = 1'b0;
   endtask

   // lat = cycles from raising start to the visible pulse, -1 on timeout.
   task automatic wait_pulse(input int limit, output int lat);
      lat = -1;
      for (int c = 1; c <= limit; c++) begin
         if (apple_valid || no_room) begin
            lat = c;
            break;
         end
         tick();
      end
   endtask

   task automatic count_pulses(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         tick();
         if (apple_valid || no_room) n++;
      end
   endtask

   function automatic int lat_bound(input int e);
      if (e == 0) return 2;
      return 1 + (128 + e - 1) / e + N + 1;
   endfunction

   function automatic void ref_place(input logic [2*N-1:0] f, input int e, input int r,
                                     output logic found, output logic [7:0] x,
                                     output logic [7:0] y);
      int k;
      int cnt;
      found = 1'b0;
      x     = 8'd0;
      y     = 8'd0;
      if (e == 0) return;
      k   = r;
      cnt = 0;
      while (k >= e) k -= e;
      for (int i = 0; i < N; i++) begin
         if (f[2*i +: 2] == 2'b00) begin
            if (cnt == k) begin
               found = 1'b1;
               x     = 8'(i % 10);
               y     = 8'(i / 10);
               return;
            end
            cnt++;
         end
      end
   endfunction

   task automatic test_reset();
      int n;
      rst         = 1'b1;
      start       = 1'b1;
      field       = all_empty;
      empty_cells = 16'd100;
      tick();
      tick();
      total++;
      if ({apple_x, apple_y} !== 16'd0) begin
         bad++;
         $display("FAIL reset_xy: got %h required 0000", {apple_x, apple_y});
      end
      total++;
      if ({apple_valid, no_room, busy} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got %b required 000", {apple_valid, no_room, busy});
      end
      total++;
      if (dut.u_lfsr.state !== SEED) begin
         bad++;
         $display("FAIL reset_lfsr: got %h required %h", dut.u_lfsr.state, SEED);
      end
      rst   = 1'b0;
      start = 1'b0;
      count_pulses(10, n);
      total++;
      if (n != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_priority: got pulses=%0d busy=%b required 0 0", n, busy);
      end
   endtask

   task automatic test_single_cell();
      logic [2*N-1:0] f;
      int   r, lat;
      exp_t e;
      f = all_block;
      f[2*57 +: 2] = 2'b00;
      for (int n = 0; n < 3; n++) begin
         repeat (n * 3) tick();
         fire(f, 16'd1, r);
         exp_q.push_back('{1'b1, 8'd7, 8'd5});
         wait_pulse(300, lat);
         e = exp_q.pop_front();
         total++;
         if (lat < 0 || {apple_valid, no_room, apple_x, apple_y} !== {e.found, ~e.found, e.x, e.y})
         begin
            bad++;
            $display("FAIL single_cell: got v=%b nr=%b x=%0d y=%0d required v=1 nr=0 x=7 y=5",
                     apple_valid, no_room, apple_x, apple_y);
         end
         last_x = e.x;
         last_y = e.y;
         total++;
         if (lat < 0 || lat > lat_bound(1)) begin
            bad++;
            $display("FAIL single_cell_latency: got %0d required <=%0d", lat, lat_bound(1));
         end
         tick();
      end
   endtask

   task automatic test_no_room_zero();
      int r, lat;
      fire(all_block, 16'd0, r);
      wait_pulse(50, lat);
      total++;
      if (lat != 2) begin
         bad++;
         $display("FAIL zero_latency: got %0d required 2", lat);
      end
      total++;
      if ({apple_valid, no_room, apple_x, apple_y} !== {2'b01, last_x, last_y}) begin
         bad++;
         $display("FAIL zero_result: got v=%b nr=%b x=%0d y=%0d required v=0 nr=1 x=%0d y=%0d",
                  apple_valid, no_room, apple_x, apple_y, last_x, last_y);
      end
      tick();
      total++;
      if ({apple_valid, no_room, busy} !== 3'b000) begin
         bad++;
         $display("FAIL zero_one_cycle: got %b required 000", {apple_valid, no_room, busy});
      end
   endtask

   task automatic test_all_empty();
      int   r, lat;
      exp_t e, p;
      for (int n = 0; n < 50; n++) begin
         repeat ($urandom_range(0, 4)) tick();
         fire(all_empty, 16'd100, r);
         field = all_block;  // post-capture changes must be ignored
         ref_place(all_empty, 100, r, e.found, e.x, e.y);
         exp_q.push_back(e);
         wait_pulse(300, lat);
         p = exp_q.pop_front();
         total++;
         if (lat < 0 || {apple_valid, no_room, apple_x, apple_y} !== {p.found, ~p.found, p.x, p.y})
         begin
            bad++;
            $display("FAIL all_empty[%0d] rand=%0d: got v=%b nr=%b x=%0d y=%0d required x=%0d y=%0d",
                     n, r, apple_valid, no_room, apple_x, apple_y, p.x, p.y);
         end
         if (p.found) begin
            last_x = p.x;
            last_y = p.y;
         end
         total++;
         if (lat < 0 || lat > lat_bound(100)) begin
            bad++;
            $display("FAIL all_empty_latency[%0d]: got %0d required <=%0d", n, lat, lat_bound(100));
         end
      end
   endtask

   task automatic test_scan_miss();
      logic [2*N-1:0] f;
      int   r, lat;
      bit   hit;
      exp_t e, p;
      f = all_block;
      f[2*3 +: 2] = 2'b00;
      hit = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         if (ref_lfsr[6:0] == 7'd2) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL scan_miss_rand: got no rand=2 within 5000 cycles required rand=2");
      end else begin
         fire(f, 16'd3, r);
         ref_place(f, 3, r, e.found, e.x, e.y);
         exp_q.push_back(e);
         wait_pulse(400, lat);
         p = exp_q.pop_front();
         total++;
         if (lat < 0 || {apple_valid, no_room, apple_x, apple_y} !== {p.found, ~p.found, last_x, last_y})
         begin
            bad++;
            $display("FAIL scan_miss: got v=%b nr=%b x=%0d y=%0d required v=0 nr=1 x=%0d y=%0d",
                     apple_valid, no_room, apple_x, apple_y, last_x, last_y);
         end
         total++;
         if (lat < N + 2 || lat > lat_bound(3)) begin
            bad++;
            $display("FAIL scan_miss_latency: got %0d required %0d..%0d", lat, N + 2, lat_bound(3));
         end
         tick();
      end
   endtask

   task automatic test_mixed();
      logic [2*N-1:0] f;
      int   r, lat, e_cnt;
      exp_t e, p;
      for (int n = 0; n < 12; n++) begin
         e_cnt = 0;
         for (int i = 0; i < N; i++) begin
            f[2*i +: 2] = 2'($urandom_range(0, 3));
            if (f[2*i +: 2] == 2'b00) e_cnt++;
         end
         if (n == 11) begin
            f     = all_empty;
            e_cnt = 150;  // overstated count
         end
         fire(f, 16'(e_cnt), r);
         ref_place(f, e_cnt, r, e.found, e.x, e.y);
         if (!e.found) begin
            e.x = last_x;
            e.y = last_y;
         end
         exp_q.push_back(e);
         wait_pulse(400, lat);
         p = exp_q.pop_front();
         total++;
         if (lat < 0 || {apple_valid, no_room, apple_x, apple_y} !== {p.found, ~p.found, p.x, p.y})
         begin
            bad++;
            $display("FAIL mixed[%0d] E=%0d rand=%0d: got v=%b nr=%b x=%0d y=%0d required v=%b x=%0d y=%0d",
                     n, e_cnt, r, apple_valid, no_room, apple_x, apple_y, p.found, p.x, p.y);
         end
         last_x = p.x;
         last_y = p.y;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int   r, lat, n;
      exp_t e, p;
      fire(all_empty, 16'd100, r);
      ref_place(all_empty, 100, r, e.found, e.x, e.y);
      exp_q.push_back(e);
      tick();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_high: got %b required 1", busy);
      end
      field       = all_block;
      empty_cells = 16'd0;
      start       = 1'b1;
      tick();
      start = 1'b0;
      wait_pulse(300, lat);
      p = exp_q.pop_front();
      total++;
      if (lat < 0 || {apple_valid, no_room, apple_x, apple_y} !== {p.found, ~p.found, p.x, p.y})
      begin
         bad++;
         $display("FAIL busy_ignore: got v=%b nr=%b x=%0d y=%0d required v=1 nr=0 x=%0d y=%0d",
                  apple_valid, no_room, apple_x, apple_y, p.x, p.y);
      end
      last_x = p.x;
      last_y = p.y;
      count_pulses(150, n);
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL busy_extra_pulses: got %0d required 0", n);
      end
   endtask

   task automatic test_reset_mid_scan();
      int r, n;
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (ref_lfsr[6:0] >= 7'd90 && ref_lfsr[6:0] <= 7'd99) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_scan_rand: got no rand in 90..99 within 4000 cycles required one");
      end else begin
         fire(all_empty, 16'd100, r);
         repeat (10) tick();
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_scan_busy: got %b required 1", busy);
         end
         rst = 1'b1;
         tick();
         total++;
         if ({apple_valid, no_room, busy, apple_x, apple_y} !== 19'd0) begin
            bad++;
            $display("FAIL mid_scan_reset: got v=%b nr=%b busy=%b x=%0d y=%0d required all 0",
                     apple_valid, no_room, busy, apple_x, apple_y);
         end
         total++;
         if (dut.u_lfsr.state !== SEED) begin
            bad++;
            $display("FAIL mid_scan_lfsr: got %h required %h", dut.u_lfsr.state, SEED);
         end
         rst    = 1'b0;
         last_x = 8'd0;
         last_y = 8'd0;
         count_pulses(150, n);
         total++;
         if (n != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_scan_aborted: got pulses=%0d busy=%b required 0 0", n, busy);
         end
      end
   endtask

   initial begin
      all_empty = '0;
      all_block = '1;
      test_reset();
      test_single_cell();
      test_no_room_zero();
      test_reset_mid_scan();
      test_all_empty();
      test_scan_miss();
      test_mixed();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
